// File: rtl/puf_input_network.sv
// puf_input_network: expands one 64-bit base challenge into NUM_PUF per-instance
// challenges with a 64-bit LFSR step, launches the PDL PUFs, waits SETTLE_CYC
// cycles and captures the combined response behind a valid/ready handshake.
// Optional build macro: PUF_INPUT_MAJORITY_EN (3-sample majority vote on the response).
module puf_input_network #(
    parameter int NUM_PUF    = 6,
    parameter int SETTLE_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           chal_in,
    input  logic                  chal_valid,
    output logic                  chal_ready,
    output logic [64*NUM_PUF-1:0] puf_chal,
    output logic                  puf_enable,
    input  logic                  xor_response,
    output logic                  resp_bit,
    output logic                  resp_valid,
    input  logic                  resp_ready
);

    localparam int IW = $clog2(NUM_PUF + 1);

    typedef enum logic [2:0] {IDLE, EXPAND, SETTLE, SAMPLE, RESP} state_t;

    state_t                   state_q, state_d;
    logic [NUM_PUF-1:0][63:0] chal_q, chal_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     resp_bit_q, resp_bit_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     puf_enable_q, puf_enable_d;
    logic                     chal_ready_q, chal_ready_d;
`ifdef PUF_INPUT_MAJORITY_EN
    logic [1:0]               samp_q, samp_d;
`endif

    // One LFSR step: shift left, feedback from taps 63/62/60/59.
    function automatic logic [63:0] lfsr_step(input logic [63:0] c);
        return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
    endfunction

    // Next-state, challenge expansion, settle/sample counting and registered outputs.
    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        resp_bit_d = resp_bit_q;
`ifdef PUF_INPUT_MAJORITY_EN
        samp_d     = samp_q;
`endif
        case (state_q)
            IDLE: begin
                if (chal_valid) begin
                    chal_d[0] = chal_in;
                    idx_d     = IW'(1);
                    state_d   = EXPAND;
                end
            end
            EXPAND: begin
                // All slices written: idx has run past the last instance.
                if (idx_q == IW'(NUM_PUF)) begin
                    state_d = SETTLE;
                    cnt_d   = 8'(SETTLE_CYC);
                end else begin
                    for (int k = 1; k < NUM_PUF; k++) begin
                        if (idx_q == IW'(k)) chal_d[k] = lfsr_step(chal_q[k-1]);
                    end
                    idx_d = idx_q + IW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd1) begin
                    state_d = SAMPLE;
`ifdef PUF_INPUT_MAJORITY_EN
                    cnt_d   = 8'd2;  // three sample cycles: 2,1,0
`else
                    cnt_d   = 8'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
`ifdef PUF_INPUT_MAJORITY_EN
                samp_d = {samp_q[0], xor_response};
                if (cnt_q == 8'd0) begin
                    resp_bit_d = (samp_q[1] & samp_q[0]) | (samp_q[1] & xor_response) |
                                 (samp_q[0] & xor_response);
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
`else
                resp_bit_d = xor_response;
                state_d    = RESP;
`endif
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        chal_ready_d = (state_d == IDLE);
        puf_enable_d = (state_d == SETTLE) || (state_d == SAMPLE);
        resp_valid_d = (state_d == RESP);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            chal_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            resp_bit_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            puf_enable_q <= 1'b0;
            chal_ready_q <= 1'b1;
`ifdef PUF_INPUT_MAJORITY_EN
            samp_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            resp_bit_q   <= resp_bit_d;
            resp_valid_q <= resp_valid_d;
            puf_enable_q <= puf_enable_d;
            chal_ready_q <= chal_ready_d;
`ifdef PUF_INPUT_MAJORITY_EN
            samp_q       <= samp_d;
`endif
        end
    end

    assign puf_chal   = chal_q;
    assign puf_enable = puf_enable_q;
    assign resp_bit   = resp_bit_q;
    assign resp_valid = resp_valid_q;
    assign chal_ready = chal_ready_q;

endmodule

// File: doc/puf_input_network.md
PUF_INPUT_NETWORK -- requirements
Module: puf_input_network

Interface
REQ-001 SHALL have parameter NUM_PUF, default 6, range 2..8: number of PDL PUF instances driven.
REQ-002 SHALL have parameter SETTLE_CYC, default 16, range 1..255: cycles between challenge apply and response sample.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port chal_in  input  64  base challenge.
REQ-006 SHALL have port chal_valid  input  1  base challenge offered.
REQ-007 SHALL have port chal_ready  output  1  block accepts base challenge.
REQ-008 SHALL have port puf_chal  output  64*NUM_PUF  per-instance challenges; slice k = bits [64k+63:64k].
REQ-009 SHALL have port puf_enable  output  1  launch strobe to PDL PUF instances.
REQ-010 SHALL have port xor_response  input  1  combined response from the output network.
REQ-011 SHALL have port resp_bit  output  1  captured response.
REQ-012 SHALL have port resp_valid  output  1  resp_bit valid.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts resp_bit.

Function
REQ-014 SHALL implement states IDLE, EXPAND, SETTLE, SAMPLE, RESP.
REQ-015 chal_ready SHALL be 1 only in IDLE; chal_valid outside IDLE ignored.
REQ-016 Accept (chal_valid&chal_ready) at edge T: slice 0 <= chal_in, idx <= 1, state EXPAND.
REQ-017 EXPAND: each cycle slice idx <= L(slice idx-1), idx++; L(c) = {c[62:0], c[63]^c[62]^c[60]^c[59]}; after slice NUM_PUF-1 written (NUM_PUF-1 cycles) go SETTLE.
REQ-018 SETTLE: puf_enable=1, counter loaded with SETTLE_CYC counts down; leave after exactly SETTLE_CYC cycles to SAMPLE.
REQ-019 SAMPLE: puf_enable stays 1; xor_response registered into resp_bit; go RESP; single SAMPLE cycle when feature of REQ-028 absent.
REQ-020 RESP: puf_enable=0, resp_valid=1, resp_bit held stable until resp_valid&resp_ready; then IDLE next cycle.
REQ-021 Latency accept edge to resp_valid rising = NUM_PUF+SETTLE_CYC+1 cycles (non-majority build).
REQ-022 puf_chal SHALL hold last values in IDLE and RESP; only changes on accept and in EXPAND.
REQ-023 resp_ready while not RESP SHALL be ignored; resp_ready held high in RESP completes in one cycle.
REQ-024 Back-to-back: earliest next accept is the cycle after RESP handshake (IDLE, chal_ready=1).

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, puf_chal all 0, idx 0, counter 0.
REQ-026 Reset values: chal_ready=1 after release, puf_enable=0, resp_bit=0, resp_valid=0.
REQ-027 Reset asserted in any state, mid-operation, SHALL abort without emitting resp_valid; first edge after release is IDLE.

Configuration
REQ-028 Macro PUF_INPUT_MAJORITY_EN defined: SAMPLE lasts 3 cycles, xor_response registered each cycle, resp_bit = majority of 3, puf_enable=1 all 3 cycles, latency = NUM_PUF+SETTLE_CYC+3.
REQ-029 Macro undefined: single-sample behaviour of REQ-019, no vote logic present.

Verification
REQ-030 Default params, chal_in=64'h0000_0000_0000_0001 accepted -> slice0=64'h1, slice1=64'h2, slice5=64'h20; puf_enable high 17 cycles (no macro); resp_valid 23 cycles after accept.
REQ-031 chal_in=64'h8000_0000_0000_0000 -> slice1=64'h1 (feedback c[63]=1); slice2=64'h2.
REQ-032 xor_response=1 in SAMPLE, resp_ready low 10 cycles in RESP -> resp_valid/resp_bit=1 stable 10 cycles; chal_valid pulses meanwhile ignored, chal_ready=0.
REQ-033 rst_n low during SETTLE (cycle 8) -> puf_enable, resp_valid 0 immediately; puf_chal=0; no response emitted; next challenge processes normally.
REQ-034 PUF_INPUT_MAJORITY_EN defined, xor_response 1,0,1 over SAMPLE -> resp_bit=1; 0,1,0 -> resp_bit=0; latency 25 cycles.
REQ-035 Two challenges with chal_valid held high, resp_ready held high -> second accepted one cycle after first RESP handshake, two responses, no overlap.
